// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings
// and the default mul/div latency.
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } hazState_e;

  localparam int DEFAULT_MULDIV_LAT = 32;

endpackage

// File: rtl/hazard_ctrl_load_use.sv
// Combinational load-use hazard compare between the load in EX and the
// source registers of the instruction in ID.
module load_use_detect (
  input  logic       exMemRead,
  input  logic [4:0] exRegisterRt,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRt,
  output logic       loadUse
);

  // A load into r0 never creates a dependency because r0 is hardwired to zero.
  assign loadUse = exMemRead && (exRegisterRt != 5'd0) &&
                   ((exRegisterRt == idRs) || (idUsesRt && (exRegisterRt == idRt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, memory
// freezes, mul/div sequencing and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = DEFAULT_MULDIV_LAT,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        IdRs_i,
  input  logic [4:0]        IdRt_i,
  input  logic              IdUsesRt_i,
  input  logic              IdMulDiv_i,
  input  logic              ExMemRead_i,
  input  logic [4:0]        ExRegisterRt_i,
  input  logic              BranchTaken_i,
  input  logic              MemStall_i,
  output logic              PcWrite_o,
  output logic              IfIdWrite_o,
  output logic              IfIdFlush_o,
  output logic              IdExBubble_o,
  output logic              PipeStall_o,
  output logic              MulDivStart_o,
  output logic              MulDivBusy_o,
  output logic [PERF_W-1:0] StallCycles_o
);

  hazState_e        state, nextState;
  logic [CNT_W-1:0] cnt, nextCnt;
  logic             loadUse;

  load_use_detect uLoadUse (
    .exMemRead    (ExMemRead_i),
    .exRegisterRt (ExRegisterRt_i),
    .idRs         (IdRs_i),
    .idRt         (IdRt_i),
    .idUsesRt     (IdUsesRt_i),
    .loadUse      (loadUse)
  );

  // Output decode in strict priority order; a memory freeze overrides any bubble.
  always_comb begin
    PcWrite_o     = 1'b1;
    IfIdWrite_o   = 1'b1;
    IfIdFlush_o   = 1'b0;
    IdExBubble_o  = 1'b0;
    PipeStall_o   = 1'b0;
    MulDivStart_o = 1'b0;
    MulDivBusy_o  = 1'b0;
    if (rst_i) begin
      PcWrite_o    = 1'b0;
      IfIdWrite_o  = 1'b0;
      IfIdFlush_o  = 1'b1;
      IdExBubble_o = 1'b1;
    end else if (MemStall_i) begin
      PcWrite_o    = 1'b0;
      IfIdWrite_o  = 1'b0;
      PipeStall_o  = 1'b1;
      MulDivBusy_o = (state == ST_MD_BUSY);
    end else if (state == ST_MD_BUSY) begin
      PcWrite_o    = 1'b0;
      IfIdWrite_o  = 1'b0;
      IdExBubble_o = 1'b1;
      MulDivBusy_o = 1'b1;
    end else if (loadUse) begin
      PcWrite_o    = 1'b0;
      IfIdWrite_o  = 1'b0;
      IdExBubble_o = 1'b1;
    end else if (BranchTaken_i) begin
      IfIdFlush_o = 1'b1;
    end else if (IdMulDiv_i) begin
      MulDivStart_o = 1'b1;
    end
  end

  // The countdown keeps running through memory stalls; the mul/div unit is independent.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      ST_RUN: begin
        if (MulDivStart_o) begin
          nextState = ST_MD_BUSY;
          nextCnt   = CNT_W'(MULDIV_LAT - 1);
        end
      end
      ST_MD_BUSY: begin
        if (cnt == '0) begin
          nextState = ST_RUN;
        end else begin
          nextCnt = cnt - 1'b1;
        end
      end
      default: nextState = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_RUN;
      cnt           <= '0;
      StallCycles_o <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (!PcWrite_o && (StallCycles_o != '1)) begin
        StallCycles_o <= StallCycles_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] idRs, idRt, exRegisterRt;
  logic       idUsesRt, idMulDiv, exMemRead, branchTaken, memStall;
  logic       pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeStall;
  logic       mulDivStart, mulDivBusy;
  logic [3:0] stallCycles;

  typedef struct {
    string      name;
    logic [6:0] flags;
    logic [3:0] stalls;
  } expect_t;

  expect_t sbQ[$];
  int      compared   = 0;
  int      mismatched = 0;

  // Flag order: {PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeStall, Start, Busy}
  localparam logic [6:0] F_RUN    = 7'b1100000;
  localparam logic [6:0] F_RST    = 7'b0011000;
  localparam logic [6:0] F_LU     = 7'b0001000;
  localparam logic [6:0] F_BR     = 7'b1110000;
  localparam logic [6:0] F_START  = 7'b1100010;
  localparam logic [6:0] F_BUSY   = 7'b0001001;
  localparam logic [6:0] F_MS     = 7'b0000100;
  localparam logic [6:0] F_MSBUSY = 7'b0000101;

  hazard_ctrl #(
    .MULDIV_LAT (4),
    .CNT_W      (6),
    .PERF_W     (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IdRs_i         (idRs),
    .IdRt_i         (idRt),
    .IdUsesRt_i     (idUsesRt),
    .IdMulDiv_i     (idMulDiv),
    .ExMemRead_i    (exMemRead),
    .ExRegisterRt_i (exRegisterRt),
    .BranchTaken_i  (branchTaken),
    .MemStall_i     (memStall),
    .PcWrite_o      (pcWrite),
    .IfIdWrite_o    (ifIdWrite),
    .IfIdFlush_o    (ifIdFlush),
    .IdExBubble_o   (idExBubble),
    .PipeStall_o    (pipeStall),
    .MulDivStart_o  (mulDivStart),
    .MulDivBusy_o   (mulDivBusy),
    .StallCycles_o  (stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input string nm, input logic r, input logic ms,
                               input logic br, input logic md, input logic mr,
                               input logic [4:0] exRt, input logic [4:0] rs,
                               input logic [4:0] rt, input logic useRt,
                               input logic [6:0] expFlags, input logic [3:0] expStalls);
    expect_t e;
    @(posedge clk);
    #1;
    rst          = r;
    memStall     = ms;
    branchTaken  = br;
    idMulDiv     = md;
    exMemRead    = mr;
    exRegisterRt = exRt;
    idRs         = rs;
    idRt         = rt;
    idUsesRt     = useRt;
    e.name   = nm;
    e.flags  = expFlags;
    e.stalls = expStalls;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    logic [6:0] actFlags;
    actFlags = {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeStall, mulDivStart, mulDivBusy};
    compared++;
    if (actFlags !== e.flags || stallCycles !== e.stalls) begin
      mismatched++;
      $display("[TB] FAIL %s: flags=%b stalls=%0d, expected flags=%b stalls=%0d",
               e.name, actFlags, stallCycles, e.flags, e.stalls);
    end
  endtask

  always @(negedge clk) begin
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
  end

  initial begin
    rst = 1'b1; memStall = 1'b0; branchTaken = 1'b0; idMulDiv = 1'b0;
    exMemRead = 1'b0; exRegisterRt = 5'd0; idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b0;

    //                 name           rst ms br md mr exRt   rs     rt     useRt flags     stalls
    applyStimulus("reset",         1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_RST,    4'd0);
    applyStimulus("idle",          0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_RUN,    4'd0);
    applyStimulus("lu rs",         0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, F_LU,     4'd0);
    applyStimulus("after lu",      0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_RUN,    4'd1);
    applyStimulus("lu r0",         0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, F_RUN,    4'd1);
    applyStimulus("lu rt",         0, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1, F_LU,     4'd1);
    applyStimulus("rt unused",     0, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, F_RUN,    4'd2);
    applyStimulus("branch+lu",     0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, F_LU,     4'd2);
    applyStimulus("branch alone",  0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_BR,     4'd3);
    applyStimulus("md start",      0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, F_START,  4'd3);
    applyStimulus("md busy1",      0, 0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, F_BUSY,   4'd3);
    applyStimulus("md busy2",      0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_BUSY,   4'd4);
    applyStimulus("md busy3",      0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_BUSY,   4'd5);
    applyStimulus("md busy4",      0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_BUSY,   4'd6);
    applyStimulus("md done",       0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_RUN,    4'd7);
    applyStimulus("md2 start",     0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, F_START,  4'd7);
    applyStimulus("md2 ms1",       0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, F_MSBUSY, 4'd7);
    applyStimulus("md2 ms2",       0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, F_MSBUSY, 4'd8);
    applyStimulus("md2 ms3",       0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, F_MSBUSY, 4'd9);
    applyStimulus("md2 busy4",     0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, F_BUSY,   4'd10);
    applyStimulus("md3 b2b start", 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, F_START,  4'd11);
    applyStimulus("md3 busy1",     0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_BUSY,   4'd11);
    applyStimulus("md3 busy2",     0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_BUSY,   4'd12);
    applyStimulus("md3 abort",     1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_RST,    4'd13);
    applyStimulus("post abort",    0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_RUN,    4'd0);
    applyStimulus("ms+lu",         0, 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, F_MS,     4'd0);
    applyStimulus("lu after ms",   0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, F_LU,     4'd1);
    applyStimulus("idle2",         0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_RUN,    4'd2);
    for (int k = 0; k < 20; k++) begin
      applyStimulus($sformatf("sat%0d", k), 0, 0, 0, 0, 1, 5'd9, 5'd0, 5'd9, 1, F_LU,
                    (k + 2 > 15) ? 4'd15 : 4'(k + 2));
    end
    applyStimulus("sat hold",      0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_RUN,    4'd15);
    applyStimulus("reset2",        1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_RST,    4'd15);
    applyStimulus("after reset2",  0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, F_RUN,    4'd0);

    for (int i = 0; i < 10 && sbQ.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sbQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
